scaler_linear_h_mc: RTL and testbench
=====================================

// Module: scaler_linear_h_mc
// PURPOSE
//  Multi-channel horizontal linear/nearest scaler for the video scaler2 path; upscales and downscales by a per-line step.
//  Arithmetic weights replace the coefficient table. Edge pixels replicate instead of zero-filling.
//  Upstream handshake is valid/ready (de_i & rdy_o); rdy_o drops only while upscaling.
//  Sits between line-buffered pixel source and vertical scaler; one output pixel max per clk.
// PARAMETERS
//  CH_COUNT     3     channels per pixel (packed, ch0 in LSBs)
//  PIXEL_WIDTH  12    bits per channel, unsigned
//  COE_WIDTH    10    weight width; unity weight W = 2^(COE_WIDTH-1)
//  SCALE_STEP   4096  1.0 scale in fixed point; power of 2, log2(SCALE_STEP) >= COE_WIDTH-1
//  CNT_WIDTH    24    position counter width
// PORTS
//  clk         in   1                     clock
//  rst         in   1                     async reset, active high
//  scale_step  in   16                    output-to-output input distance; <SCALE_STEP upscales
//  mode        in   1                     0 linear, 1 nearest neighbour
//  di_i        in   CH_COUNT*PIXEL_WIDTH  input pixel
//  de_i        in   1                     input valid
//  hs_i        in   1                     line sync, level: high = between lines
//  vs_i        in   1                     frame sync, passed through
//  rdy_o       out  1                     ready; pixel accepted when de_i & rdy_o
//  do_o        out  CH_COUNT*PIXEL_WIDTH  output pixel
//  de_o        out  1                     output valid
//  hs_o, vs_o  out  1                     delayed syncs
// BEHAVIOUR
//  Reset: do_o=0, de_o=hs_o=vs_o=0, pipeline cleared, state S_WAIT; rdy_o forced 0 while rst high.
//  States:
//   S_WAIT: rdy_o=1, accepted pixels discarded.
//   S_LINE: entered cycle after hs_i high.
//  Line start, any state: hs_i=1 forces next-cycle state S_LINE.
//   pos=0, lim=0, pair=0; scale_step latched (0 -> SCALE_STEP). mode also latched.
//   Accept in an hs_i=1 cycle is discarded. Mid-line scale_step/mode changes are ignored.
//  Accept in S_LINE, i.e. de_i&rdy_o&!hs_i:
//   first pixel: pix_a=pix_b=di_i, lim=0, pair=1.
//   later pixels: pix_a<=pix_b, pix_b<=di_i, lim<=lim+SCALE_STEP.
//  Emit: each cycle with pair & pos<lim, issue a sample from current pix_a/pix_b, then pos+=step.
//   Emit and accept may share a cycle; the emit uses the pre-accept pair.
//  rdy_o (S_LINE) = !(pos<lim) | (pos+step>=lim), meaning at most one output is pending.
//   Upscale therefore stalls upstream; bypass and downscale run at full rate.
//  Right edge: outputs needing a pixel beyond the last accepted one are never emitted.
//   N pixels -> ceil((N-1)*SCALE_STEP/step) outputs.
//  Weights: frac = pos[log2(SCALE_STEP)-1:0].
//   Linear: c1 = frac >> (log2(SCALE_STEP)-COE_WIDTH+1), c0 = W-c1.
//   Nearest: c1 = (frac>=SCALE_STEP/2) ? W : 0, c0 = W-c1.
//  Per channel: s = c0*a + c1*b + 2^(COE_WIDTH-2); y = s>>(COE_WIDTH-1), saturated to 2^PIXEL_WIDTH-1.
//  Latency: emit cycle t -> do_o/de_o at t+4; de_o high exactly one cycle per emit.
//   Pipeline: t+1 weights, t+2 mult, t+3 sum, t+4 saturate.
//   hs_o/vs_o = hs_i/vs_i delayed 4 cycles.
//  pos/lim counters must not wrap within a line: N*SCALE_STEP < 2^CNT_WIDTH.
//  Async reset mid-line aborts the line. The next line requires hs_i; no partial output emitted.
// TESTING
//  Bypass:
//   step=4096, mode0, ch0 pixels 0,100..700, de_i continuous.
//   -> 7 outputs 0,100..600; rdy_o stays 1.
//  Upscale 2x:
//   step=2048, pixels 0,400,800.
//   -> outputs 0,200,400,600; rdy_o low every other cycle after pixel1.
//  Downscale 2x:
//   step=8192, pixels 0,100..700.
//   -> outputs 0,200,400,600; rdy_o stays 1.
//  Nearest:
//   mode=1, step=2048, pixels 0,400 on all 3 channels.
//   -> outputs 0 then 400 on every channel.
//  Full scale:
//   all channels 4095, step=3000, linear.
//   -> every output 4095, no wrap; independent channel values stay uncorrupted.
//  Restart:
//   hs_i mid-line, then rst mid-emit.
//   -> line restarts with pos=0; after rst, de_o stays 0 until hs_i plus two accepted pixels.

Source files
------------

// File: rtl/scaler_linear_h_mc_if.sv
// Pixel stream bundle for the horizontal scaler: upstream pixels/syncs/config in,
// scaled pixels and delayed syncs out.
interface scaler_linear_h_mc_if #(
   parameter int CH_COUNT    = 3,
   parameter int PIXEL_WIDTH = 12
);
   localparam int DW = CH_COUNT * PIXEL_WIDTH;

   logic [15:0]   scale_step;
   logic          mode;
   logic [DW-1:0] di_i;
   logic          de_i;
   logic          hs_i;
   logic          vs_i;
   logic          rdy_o;
   logic [DW-1:0] do_o;
   logic          de_o;
   logic          hs_o;
   logic          vs_o;

   modport slave (
      input  scale_step, mode, di_i, de_i, hs_i, vs_i,
      output rdy_o, do_o, de_o, hs_o, vs_o
   );

   modport master (
      output scale_step, mode, di_i, de_i, hs_i, vs_i,
      input  rdy_o, do_o, de_o, hs_o, vs_o
   );
endinterface

// File: rtl/scaler_linear_h_mc.sv
// Multi-channel horizontal linear/nearest scaler: a position counter walks the input
// line by a per-line step and each sample is blended from the current pixel pair.
module scaler_linear_h_mc #(
   parameter int CH_COUNT    = 3,
   parameter int PIXEL_WIDTH = 12,
   parameter int COE_WIDTH   = 10,
   parameter int SCALE_STEP  = 4096,
   parameter int CNT_WIDTH   = 24
) (
   input logic                 clk,
   input logic                 rst,
   scaler_linear_h_mc_if.slave bus
);
   localparam int DW      = CH_COUNT * PIXEL_WIDTH;
   localparam int FRAC_W  = $clog2(SCALE_STEP);
   localparam int C_SHIFT = FRAC_W - COE_WIDTH + 1;
   localparam int PROD_W  = COE_WIDTH + PIXEL_WIDTH;
   localparam int SUM_W   = PROD_W + 1;
   localparam int SH_W    = SUM_W - (COE_WIDTH - 1);

   localparam logic [COE_WIDTH-1:0]   W_UNITY  = COE_WIDTH'(2 ** (COE_WIDTH - 1));
   localparam logic [SUM_W-1:0]       ROUND    = SUM_W'(2 ** (COE_WIDTH - 2));
   localparam logic [CNT_WIDTH-1:0]   STEP_ONE = CNT_WIDTH'(SCALE_STEP);
   localparam logic [PIXEL_WIDTH-1:0] PIX_MAX  = '1;

   typedef enum logic {S_WAIT = 1'b0, S_LINE = 1'b1} state_t;

   state_t               state_q, state_d;
   logic [CNT_WIDTH-1:0] pos_q, pos_d;
   logic [CNT_WIDTH-1:0] lim_q, lim_d;
   logic [CNT_WIDTH-1:0] step_q, step_d;
   logic                 mode_q, mode_d;
   logic                 pair_q, pair_d;
   logic [DW-1:0]        pix_a_q, pix_a_d;
   logic [DW-1:0]        pix_b_q, pix_b_d;

   logic pending, last_pending, rdy, accept, emit;
   logic [COE_WIDTH-1:0] c1_d;

   // Ready holds while no more than one sample of the current pair remains to be issued.
   assign pending      = pos_q < lim_q;
   assign last_pending = (pos_q + step_q) >= lim_q;
   assign rdy          = (state_q == S_WAIT) || !pending || last_pending;
   assign accept       = bus.de_i && rdy && !bus.hs_i && (state_q == S_LINE);
   assign emit         = (state_q == S_LINE) && pair_q && pending && !bus.hs_i;
   assign bus.rdy_o    = rdy && !rst;

   always_comb begin : ctrl_next
      // NOTE: every variable takes its hold value first, so no branch can leave one unassigned and infer a latch.
      state_d = state_q;
      pos_d   = pos_q;
      lim_d   = lim_q;
      step_d  = step_q;
      mode_d  = mode_q;
      pair_d  = pair_q;
      pix_a_d = pix_a_q;
      pix_b_d = pix_b_q;
      if (bus.hs_i) begin
         state_d = S_LINE;
         pos_d   = '0;
         lim_d   = '0;
         pair_d  = 1'b0;
         step_d  = (bus.scale_step == '0) ? STEP_ONE : CNT_WIDTH'(bus.scale_step);
         mode_d  = bus.mode;
      end else begin
         if (emit) pos_d = pos_q + step_q;
         if (accept) begin
            if (!pair_q) begin
               pix_a_d = bus.di_i;
               pix_b_d = bus.di_i;
               pair_d  = 1'b1;
            end else begin
               pix_a_d = pix_b_q;
               pix_b_d = bus.di_i;
               lim_d   = lim_q + STEP_ONE;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin : ctrl_regs
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         state_q <= S_WAIT;
         pos_q   <= '0;
         lim_q   <= '0;
         step_q  <= STEP_ONE;
         mode_q  <= 1'b0;
         pair_q  <= 1'b0;
         pix_a_q <= '0;
         pix_b_q <= '0;
      end else begin
         state_q <= state_d;
         pos_q   <= pos_d;
         lim_q   <= lim_d;
         step_q  <= step_d;
         mode_q  <= mode_d;
         pair_q  <= pair_d;
         pix_a_q <= pix_a_d;
         pix_b_q <= pix_b_d;
      end
   end

   // Weight of the right-hand pixel comes straight from the fractional position.
   always_comb begin : weights
      if (mode_q) c1_d = pos_q[FRAC_W-1] ? W_UNITY : '0;
      else        c1_d = {1'b0, pos_q[FRAC_W-1:C_SHIFT]};
   end

   logic                   v1_q, v2_q, v3_q, de_q;
   logic [COE_WIDTH-1:0]   c0_q, c1_q;
   logic [DW-1:0]          a1_q, b1_q, do_q;
   logic [PROD_W-1:0]      p0_q [CH_COUNT];
   logic [PROD_W-1:0]      p1_q [CH_COUNT];
   logic [SH_W-1:0]        sh_q [CH_COUNT];
   logic [3:0]             hs_dly_q, vs_dly_q;

   always_ff @(posedge clk or posedge rst) begin : datapath
      if (rst) begin
         v1_q     <= 1'b0;
         v2_q     <= 1'b0;
         v3_q     <= 1'b0;
         de_q     <= 1'b0;
         c0_q     <= '0;
         c1_q     <= '0;
         a1_q     <= '0;
         b1_q     <= '0;
         do_q     <= '0;
         hs_dly_q <= '0;
         vs_dly_q <= '0;
         for (int c = 0; c < CH_COUNT; c++) begin
            p0_q[c] <= '0;
            p1_q[c] <= '0;
            sh_q[c] <= '0;
         end
      end else begin
         v1_q     <= emit;
         v2_q     <= v1_q;
         v3_q     <= v2_q;
         de_q     <= v3_q;
         hs_dly_q <= {hs_dly_q[2:0], bus.hs_i};
         vs_dly_q <= {vs_dly_q[2:0], bus.vs_i};
         if (emit) begin
            c1_q <= c1_d;
            c0_q <= W_UNITY - c1_d;
            a1_q <= pix_a_q;
            b1_q <= pix_b_q;
         end
         for (int c = 0; c < CH_COUNT; c++) begin
            if (v1_q) begin
               p0_q[c] <= PROD_W'(c0_q) * PROD_W'(a1_q[c*PIXEL_WIDTH +: PIXEL_WIDTH]);
               p1_q[c] <= PROD_W'(c1_q) * PROD_W'(b1_q[c*PIXEL_WIDTH +: PIXEL_WIDTH]);
            end
            if (v2_q)
               sh_q[c] <= SH_W'((SUM_W'(p0_q[c]) + SUM_W'(p1_q[c]) + ROUND) >> (COE_WIDTH - 1));
            if (v3_q)
               do_q[c*PIXEL_WIDTH +: PIXEL_WIDTH] <= (|sh_q[c][SH_W-1:PIXEL_WIDTH]) ?
                                                     PIX_MAX : sh_q[c][PIXEL_WIDTH-1:0];
         end
      end
   end

   assign bus.do_o = do_q;
   assign bus.de_o = de_q;
   assign bus.hs_o = hs_dly_q[3];
   assign bus.vs_o = vs_dly_q[3];
endmodule

// File: tb/tb_scaler_linear_h_mc.sv
// Directed bench for scaler_linear_h_mc: a table of per-line vectors plus hand-written
// sequences for sync delay, line restart and asynchronous reset.
module tb_scaler_linear_h_mc;
   localparam int CH   = 3;
   localparam int PW   = 12;
   localparam int DW   = CH * PW;
   localparam int MAXP = 8;
   localparam int NVM  = 12;

   typedef logic [DW-1:0] pix_t;
   typedef struct packed {
      logic [15:0]                 step;
      logic                        mode;
      int                          n_pix;
      logic [MAXP-1:0][DW-1:0]     pix;
      int                          n_out;
      logic [MAXP-1:0][DW-1:0]     exp_out;
      int                          exp_stalls;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   scaler_linear_h_mc_if #(.CH_COUNT(CH), .PIXEL_WIDTH(PW)) bus ();

   scaler_linear_h_mc #(
      .CH_COUNT(CH), .PIXEL_WIDTH(PW), .COE_WIDTH(10), .SCALE_STEP(4096), .CNT_WIDTH(24)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   vec_t  vecs [NVM];
   string vname [NVM];
   int    nv = 0;
   int    n_tests = 0;
   int    n_fail = 0;
   pix_t  got [$];

   always @(negedge clk) if (bus.de_o === 1'b1) got.push_back(bus.do_o);

   function automatic pix_t pk(input int c0, input int c1, input int c2);
      return {PW'(c2), PW'(c1), PW'(c0)};
   endfunction

   function automatic pix_t mono(input int v);
      return pk(v, v, v);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic new_vec(input string nm, input logic [15:0] st, input logic md, input int stl);
      vname[nv]           = nm;
      vecs[nv]            = '0;
      vecs[nv].step       = st;
      vecs[nv].mode       = md;
      vecs[nv].exp_stalls = stl;
      nv++;
   endtask

   task automatic add_in(input pix_t p);
      vecs[nv-1].pix[vecs[nv-1].n_pix] = p;
      vecs[nv-1].n_pix++;
   endtask

   task automatic add_out(input pix_t p);
      vecs[nv-1].exp_out[vecs[nv-1].n_out] = p;
      vecs[nv-1].n_out++;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic start_line(input logic [15:0] st, input logic md);
      bus.scale_step = st;
      bus.mode       = md;
      bus.de_i       = 1'b0;
      bus.hs_i       = 1'b1;
      idle(2);
      bus.hs_i       = 1'b0;
   endtask

   // Offers one pixel until it is accepted; counts cycles spent with rdy_o low.
   task automatic push(input pix_t px, output int stalls);
      bit done;
      done       = 1'b0;
      stalls     = 0;
      bus.di_i   = px;
      bus.de_i   = 1'b1;
      for (int k = 0; k < 32 && !done; k++) begin
         @(negedge clk);
         if (bus.rdy_o === 1'b1) done = 1'b1;
         else stalls++;
         @(posedge clk);
         #1;
      end
      bus.de_i = 1'b0;
      if (!done) begin
         n_tests++;
         n_fail++;
         $display("FAIL accept timeout: rdy_o never high for pixel %0h", px);
      end
   endtask

   task automatic run_vec(input int vi);
      int stalls, st;
      start_line(vecs[vi].step, vecs[vi].mode);
      got.delete();
      stalls = 0;
      for (int i = 0; i < vecs[vi].n_pix; i++) begin
         push(vecs[vi].pix[i], st);
         stalls += st;
      end
      idle(12);
      check($sformatf("%s count", vname[vi]), 64'(got.size()), 64'(vecs[vi].n_out));
      for (int i = 0; i < vecs[vi].n_out; i++)
         check($sformatf("%s out%0d", vname[vi], i),
               (i < got.size()) ? 64'(got[i]) : 64'hx, 64'(vecs[vi].exp_out[i]));
      if (vecs[vi].exp_stalls >= 0)
         check($sformatf("%s stalls", vname[vi]), 64'(stalls), 64'(vecs[vi].exp_stalls));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int st;

      new_vec("bypass", 16'd4096, 1'b0, 0);
      for (int i = 0; i < 8; i++) add_in(mono(100 * i));
      for (int i = 0; i < 7; i++) add_out(mono(100 * i));
      new_vec("up2x", 16'd2048, 1'b0, 1);
      add_in(mono(0)); add_in(mono(400)); add_in(mono(800));
      add_out(mono(0)); add_out(mono(200)); add_out(mono(400)); add_out(mono(600));
      new_vec("down2x", 16'd8192, 1'b0, 0);
      for (int i = 0; i < 8; i++) add_in(mono(100 * i));
      for (int i = 0; i < 4; i++) add_out(mono(200 * i));
      new_vec("nearest", 16'd2048, 1'b1, 0);
      add_in(mono(0)); add_in(mono(400));
      add_out(mono(0)); add_out(mono(400));
      new_vec("fullscale", 16'd3000, 1'b0, -1);
      for (int i = 0; i < 4; i++) add_in(mono(4095));
      for (int i = 0; i < 5; i++) add_out(mono(4095));
      new_vec("chan_const", 16'd3000, 1'b0, -1);
      for (int i = 0; i < 3; i++) add_in(pk(4095, 0, 2048));
      for (int i = 0; i < 3; i++) add_out(pk(4095, 0, 2048));
      new_vec("chan_mix", 16'd2048, 1'b0, 0);
      add_in(pk(0, 10, 1000)); add_in(pk(4095, 30, 0));
      add_out(pk(0, 10, 1000)); add_out(pk(2048, 20, 500));
      new_vec("frac075", 16'd3072, 1'b0, -1);
      add_in(mono(0)); add_in(mono(1024)); add_in(mono(2048));
      add_out(mono(0)); add_out(mono(768)); add_out(mono(1536));
      new_vec("step0", 16'd0, 1'b0, 0);
      add_in(mono(0)); add_in(mono(100)); add_in(mono(200));
      add_out(mono(0)); add_out(mono(100));

      bus.scale_step = 16'd4096;
      bus.mode       = 1'b0;
      bus.di_i       = '0;
      bus.de_i       = 1'b0;
      bus.hs_i       = 1'b0;
      bus.vs_i       = 1'b0;

      repeat (3) @(negedge clk);
      check("reset de_o", 64'(bus.de_o), 64'd0);
      check("reset do_o", 64'(bus.do_o), 64'd0);
      check("reset hs_o", 64'(bus.hs_o), 64'd0);
      check("reset vs_o", 64'(bus.vs_o), 64'd0);
      check("reset rdy_o", 64'(bus.rdy_o), 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      idle(1);
      check("wait rdy_o", 64'(bus.rdy_o), 64'd1);

      // Pixels offered before any line start are swallowed.
      got.delete();
      push(mono(300), st);
      push(mono(500), st);
      push(mono(700), st);
      idle(10);
      check("wait discard", 64'(got.size()), 64'd0);

      // Sync delay: four register stages.
      bus.hs_i = 1'b1;
      bus.vs_i = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("hs_o t+3", 64'(bus.hs_o), 64'd0);
      @(negedge clk);
      check("hs_o t+4", 64'(bus.hs_o), 64'd1);
      check("vs_o t+4", 64'(bus.vs_o), 64'd1);
      @(posedge clk);
      #1;
      bus.hs_i = 1'b0;
      bus.vs_i = 1'b0;
      idle(6);

      for (int v = 0; v < nv; v++) run_vec(v);

      // Line start in the middle of a line restarts the position counter.
      start_line(16'd4096, 1'b0);
      push(mono(0), st);
      push(mono(100), st);
      push(mono(200), st);
      start_line(16'd4096, 1'b0);
      idle(6);
      got.delete();
      push(mono(1000), st);
      push(mono(2000), st);
      idle(12);
      check("restart count", 64'(got.size()), 64'd1);
      check("restart out0", (got.size() > 0) ? 64'(got[0]) : 64'hx, 64'(mono(1000)));

      // Asynchronous reset while upscaled samples are in flight.
      start_line(16'd1024, 1'b0);
      push(mono(0), st);
      push(mono(400), st);
      idle(2);
      #2 rst = 1'b1;
      #1;
      check("rst de_o", 64'(bus.de_o), 64'd0);
      check("rst do_o", 64'(bus.do_o), 64'd0);
      check("rst rdy_o", 64'(bus.rdy_o), 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      got.delete();
      push(mono(100), st);
      push(mono(200), st);
      idle(10);
      check("rst no line", 64'(got.size()), 64'd0);
      start_line(16'd4096, 1'b0);
      push(mono(100), st);
      idle(10);
      check("rst one pixel", 64'(got.size()), 64'd0);
      push(mono(200), st);
      idle(10);
      check("rst two pixels", 64'(got.size()), 64'd1);
      check("rst out0", (got.size() > 0) ? 64'(got[0]) : 64'hx, 64'(mono(100)));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
